// File: rtl/fsm_traffic_ctrl.sv
// Highway / farm-road traffic light controller: four-phase Moore lamp FSM with
// a Mealy start-timer pulse issued on every phase change.
module fsm_traffic_ctrl (
  input  logic Clk,
  input  logic reset,
  input  logic TS,
  input  logic TL,
  input  logic C,
  output logic MR,
  output logic MY,
  output logic MG,
  output logic SR,
  output logic SY,
  output logic SG,
  output logic ST
);

  typedef enum logic [1:0] {
    HG = 2'b00,
    HY = 2'b01,
    FG = 2'b10,
    FY = 2'b11
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge Clk) begin
    if (!reset) state_q <= HG;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ST      = 1'b0;
    MR      = 1'b0;
    MY      = 1'b0;
    MG      = 1'b0;
    SR      = 1'b0;
    SY      = 1'b0;
    SG      = 1'b0;
    unique case (state_q)
      HG: begin
        MG = 1'b1;
        SR = 1'b1;
        if (TL && C) begin
          state_d = HY;
          ST      = 1'b1;
        end
      end
      HY: begin
        MY = 1'b1;
        SR = 1'b1;
        if (TS) begin
          state_d = FG;
          ST      = 1'b1;
        end
      end
      FG: begin
        MR = 1'b1;
        SG = 1'b1;
        if (TL || !C) begin
          state_d = FY;
          ST      = 1'b1;
        end
      end
      FY: begin
        MR = 1'b1;
        SY = 1'b1;
        if (TS) begin
          state_d = HG;
          ST      = 1'b1;
        end
      end
      // Unreachable with a full 2-bit encoding, kept as a safe recovery path.
      default: begin
        MG      = 1'b1;
        SR      = 1'b1;
        state_d = HG;
      end
    endcase
    // The timer must not be kicked while the controller is held in reset.
    if (!reset) ST = 1'b0;
  end

endmodule

// File: tb/tb_fsm_traffic_ctrl.sv
// Directed bench for fsm_traffic_ctrl: expected ST and lamp patterns are queued
// as each step is driven and checked when the DUT produces them.
module tb_fsm_traffic_ctrl;

  logic Clk = 1'b0;
  logic reset = 1'b0;
  logic TS = 1'b0;
  logic TL = 1'b0;
  logic C = 1'b0;
  logic MR, MY, MG, SR, SY, SG, ST;

  // Lamp vectors as {MR,MY,MG,SR,SY,SG}
  localparam logic [5:0] L_HG = 6'b001_100;
  localparam logic [5:0] L_HY = 6'b010_100;
  localparam logic [5:0] L_FG = 6'b100_001;
  localparam logic [5:0] L_FY = 6'b100_010;

  typedef struct {
    logic       st;
    logic [5:0] lamps;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  fsm_traffic_ctrl dut (
    .Clk(Clk), .reset(reset), .TS(TS), .TL(TL), .C(C),
    .MR(MR), .MY(MY), .MG(MG), .SR(SR), .SY(SY), .SG(SG), .ST(ST)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic rst, input logic ts, input logic tl,
                      input logic c, input logic exp_st,
                      input logic [5:0] exp_lamps, input string tag);
    exp_t e;
    logic [5:0] lamps;
    @(negedge Clk);
    reset = rst;
    TS = ts;
    TL = tl;
    C = c;
    exp_q.push_back('{st: exp_st, lamps: exp_lamps, tag: tag});
    #1;
    e = exp_q[0];
    checks++;
    assert (ST === e.st) else begin
      errors++;
      $error("FAIL %s_st observed=%b expected=%b", e.tag, ST, e.st);
    end
    @(posedge Clk);
    #1;
    e = exp_q.pop_front();
    lamps = {MR, MY, MG, SR, SY, SG};
    checks++;
    assert (lamps === e.lamps) else begin
      errors++;
      $error("FAIL %s_lamps observed=%b expected=%b", e.tag, lamps, e.lamps);
    end
    checks++;
    assert (($countones(lamps[5:3]) == 1) && ($countones(lamps[2:0]) == 1)
            && (MR || SR)) else begin
      errors++;
      $error("FAIL %s_onehot observed=%b expected=one_main_one_side", e.tag, lamps);
    end
  endtask

  initial begin
    // Reset with arbitrary inputs
    step(0, 1, 1, 1, 0, L_HG, "rst0");
    step(0, 0, 1, 0, 0, L_HG, "rst1");
    // HG: TL without a car stays
    step(1, 1, 1, 0, 0, L_HG, "hg_nocar");
    step(1, 1, 0, 1, 0, L_HG, "hg_notl");
    step(1, 0, 1, 1, 1, L_HY, "hg_go");
    // HY holds while TS=0 regardless of TL/C
    for (int i = 0; i < 5; i++)
      step(1, 0, i[0], ~i[0], 0, L_HY, "hy_hold");
    step(1, 1, 0, 1, 1, L_FG, "hy_go");
    // FG holds while car present and TL=0; TS ignored
    for (int i = 0; i < 5; i++)
      step(1, i[0], 0, 1, 0, L_FG, "fg_hold");
    step(1, 0, 1, 1, 1, L_FY, "fg_tl");
    // FY holds while TS=0
    for (int i = 0; i < 5; i++)
      step(1, 0, i[0], i[1], 0, L_FY, "fy_hold");
    step(1, 1, 0, 0, 1, L_HG, "fy_go");
    // Full cycle with FG exiting on C=0
    step(1, 0, 1, 1, 1, L_HY, "cyc_hg");
    step(1, 1, 0, 0, 1, L_FG, "cyc_hy");
    step(1, 0, 0, 0, 1, L_FY, "cyc_fg_nocar");
    step(1, 1, 0, 0, 1, L_HG, "cyc_fy");
    // TS held across HY->FG: FG evaluates its own condition next
    step(1, 1, 1, 1, 1, L_HY, "hold_hg");
    step(1, 1, 0, 1, 1, L_FG, "hold_hy");
    step(1, 1, 0, 1, 0, L_FG, "hold_fg");
    // Reset in FG overrides the pending transition and masks ST
    step(0, 0, 1, 1, 0, L_HG, "rst_fg");
    step(1, 0, 1, 0, 0, L_HG, "post_rst");
    step(1, 0, 1, 1, 1, L_HY, "post_rst_go");
    // Reset in HY with TS=1
    step(0, 1, 0, 0, 0, L_HG, "rst_hy");
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
